// File: rtl/bp_mii_link_fabric_if.sv
// MII fabric bundle: per-chip transmit/receive lanes, receiver link state
// and per-receiver frame counters.
// Optional BP_MII_LINK_ERR_INJECT_EN adds a per-receiver error-inject lane.
interface bp_mii_link_fabric_if #(
  parameter int unsigned num_chips_p = 2,
  parameter int unsigned cnt_width_p = 16
);

  logic [4*num_chips_p-1:0]           mii_txd_i;
  logic [num_chips_p-1:0]             mii_tx_en_i;
  logic [num_chips_p-1:0]             mii_tx_er_i;
  logic [num_chips_p-1:0]             link_up_i;
  logic [4*num_chips_p-1:0]           mii_rxd_o;
  logic [num_chips_p-1:0]             mii_rx_dv_o;
  logic [num_chips_p-1:0]             mii_rx_er_o;
  logic [cnt_width_p*num_chips_p-1:0] frame_count_o;
  logic [cnt_width_p*num_chips_p-1:0] err_count_o;

`ifdef BP_MII_LINK_ERR_INJECT_EN
  logic [num_chips_p-1:0]             inject_i;

  // Chip-testbench side: drives transmit lanes, observes receive lanes
  modport master (
    output mii_txd_i, mii_tx_en_i, mii_tx_er_i, link_up_i, inject_i,
    input  mii_rxd_o, mii_rx_dv_o, mii_rx_er_o, frame_count_o, err_count_o
  );

  // Fabric side
  modport slave (
    input  mii_txd_i, mii_tx_en_i, mii_tx_er_i, link_up_i, inject_i,
    output mii_rxd_o, mii_rx_dv_o, mii_rx_er_o, frame_count_o, err_count_o
  );
`else
  // Chip-testbench side: drives transmit lanes, observes receive lanes
  modport master (
    output mii_txd_i, mii_tx_en_i, mii_tx_er_i, link_up_i,
    input  mii_rxd_o, mii_rx_dv_o, mii_rx_er_o, frame_count_o, err_count_o
  );

  // Fabric side
  modport slave (
    input  mii_txd_i, mii_tx_en_i, mii_tx_er_i, link_up_i,
    output mii_rxd_o, mii_rx_dv_o, mii_rx_er_o, frame_count_o, err_count_o
  );
`endif

endinterface

// File: rtl/bp_mii_link_fabric.sv
// Multi-chip MII interconnect: routes each receiver from a fixed source
// (pairwise crossover or ring), delays the tuple by latency_p cycles and
// runs a per-receiver link-state FSM that truncates frames on link drop.
// Keeps saturating good/bad frame counters per receiver.
// Optional feature macro: BP_MII_LINK_ERR_INJECT_EN (per-receiver er inject).
module bp_mii_link_fabric #(
  parameter int unsigned num_chips_p = 2,
  parameter int unsigned latency_p   = 1,
  parameter int unsigned mode_p      = 0,
  parameter int unsigned cnt_width_p = 16
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  bp_mii_link_fabric_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [cnt_width_p-1:0] CNT_MAX = '1;

  // Elaboration-time parameter sanity
  if (num_chips_p < 2) begin : g_bad_chips
    $error("bp_mii_link_fabric: num_chips_p must be >= 2");
  end
  if (latency_p < 1) begin : g_bad_latency
    $error("bp_mii_link_fabric: latency_p must be >= 1");
  end
  if (mode_p > 1) begin : g_bad_mode
    $error("bp_mii_link_fabric: mode_p must be 0 or 1");
  end
  if ((mode_p == 0) && ((num_chips_p % 2) != 0)) begin : g_bad_pairing
    $error("bp_mii_link_fabric: pairwise mode needs an even num_chips_p");
  end

  for (genvar r = 0; r < num_chips_p; r++) begin : g_rx

    localparam int unsigned SRC = (mode_p == 0) ? (r ^ 1)
                                                : ((r + num_chips_p - 1) % num_chips_p);

    // Tuple layout: [6] previous tx_en, [5] tx_er, [4] tx_en, [3:0] txd
    logic       r_prev_en;
    logic [6:0] w_src;
    logic [6:0] w_d;
    logic       w_d_prev;
    logic       w_d_er;
    logic       w_d_en;
    logic [3:0] w_d_txd;
    logic       w_link;
    logic       w_inject;

    // The previous tx_en travels with each tuple instead of being sampled
    // at the FSM; it resets high so a frame still in flight when reset
    // releases never looks like a fresh start.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_prev_en <= 1'b1;
      else            r_prev_en <= bus.mii_tx_en_i[SRC];
    end

    assign w_src = {r_prev_en,
                    bus.mii_tx_er_i[SRC],
                    bus.mii_tx_en_i[SRC],
                    bus.mii_txd_i[4*SRC +: 4]};

    if (latency_p == 1) begin : g_direct
      assign w_d = w_src;
    end else begin : g_pipe
      logic [6:0] r_pipe [latency_p-1];

      // Delay line; the FSM output register supplies the final stage
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          for (int unsigned k = 0; k < latency_p - 1; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_src;
          for (int unsigned k = 1; k < latency_p - 1; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign w_d = r_pipe[latency_p-2];
    end

    assign {w_d_prev, w_d_er, w_d_en, w_d_txd} = w_d;
    assign w_link = bus.link_up_i[r];

`ifdef BP_MII_LINK_ERR_INJECT_EN
    assign w_inject = bus.inject_i[r];
`else
    assign w_inject = 1'b0;
`endif

    state_e                 r_state;
    state_e                 w_state_nx;
    logic                   r_bad;
    logic                   w_bad_nx;
    logic [3:0]             r_rxd;
    logic [3:0]             w_rxd_nx;
    logic                   r_dv;
    logic                   w_dv_nx;
    logic                   r_er;
    logic                   w_er_nx;
    logic                   w_frame_inc;
    logic                   w_err_inc;
    logic [cnt_width_p-1:0] r_frame_cnt;
    logic [cnt_width_p-1:0] r_err_cnt;

    // Link-state next-state, next receive outputs and counter strobes
    always_comb begin
      w_state_nx  = r_state;
      w_bad_nx    = r_bad;
      w_rxd_nx    = '0;
      w_dv_nx     = 1'b0;
      w_er_nx     = 1'b0;
      w_frame_inc = 1'b0;
      w_err_inc   = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_d_en && !w_d_prev && w_link) begin
            w_state_nx = ST_PASS;
            w_rxd_nx   = w_d_txd;
            w_dv_nx    = 1'b1;
            w_er_nx    = w_d_er;
            w_bad_nx   = w_d_er;
          end
        end
        ST_PASS: begin
          if (w_d_en && !w_link) begin
            w_state_nx = ST_DROP;
            w_dv_nx    = 1'b1;
            w_er_nx    = 1'b1;
            w_err_inc  = 1'b1;
            w_bad_nx   = 1'b0;
          end else begin
            w_rxd_nx = w_d_txd;
            w_dv_nx  = w_d_en;
            w_er_nx  = w_d_er | w_inject;
            if (w_d_en) begin
              w_bad_nx = r_bad | w_d_er | w_inject;
            end else begin
              w_state_nx = ST_IDLE;
              w_bad_nx   = 1'b0;
              if (r_bad || w_inject) w_err_inc   = 1'b1;
              else                   w_frame_inc = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!w_d_en) w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    // State, sticky error flag and registered receive outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_state <= ST_IDLE;
        r_bad   <= 1'b0;
        r_rxd   <= '0;
        r_dv    <= 1'b0;
        r_er    <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_bad   <= w_bad_nx;
        r_rxd   <= w_rxd_nx;
        r_dv    <= w_dv_nx;
        r_er    <= w_er_nx;
      end
    end

    // Saturating per-receiver frame counters
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_frame_cnt <= '0;
        r_err_cnt   <= '0;
      end else begin
        if (w_frame_inc && (r_frame_cnt != CNT_MAX)) r_frame_cnt <= r_frame_cnt + 1'b1;
        if (w_err_inc && (r_err_cnt != CNT_MAX))     r_err_cnt   <= r_err_cnt + 1'b1;
      end
    end

    assign bus.mii_rxd_o[4*r +: 4]                    = r_rxd;
    assign bus.mii_rx_dv_o[r]                         = r_dv;
    assign bus.mii_rx_er_o[r]                         = r_er;
    assign bus.frame_count_o[cnt_width_p*r +: cnt_width_p] = r_frame_cnt;
    assign bus.err_count_o[cnt_width_p*r +: cnt_width_p]   = r_err_cnt;
  end

endmodule
